brq_regfile_mp: RTL

Parametrised multi-port integer register file, the successor to the single-write/dual-read core register file.
- Configurable read and write port counts, optional write-to-read bypass.
- Per-register pending-write scoreboard for a pipelined core with out-of-order writeback.
- Registered debug read port and a fixed tap output for board-level observation.
- Sits between decode (reads, reservations) and writeback (writes) in the BURAQ pipeline.

---
 rtl/brq_regfile_mp.sv | 121 ++++++++++++
 1 files changed

// File: rtl/brq_regfile_mp.sv
// brq_regfile_mp: multi-port integer register file for the BURAQ pipeline.
// It has NUM_RD combinational read ports and NUM_WR write ports, with an optional
// write-to-read bypass. A pending-write scoreboard tracks out-of-order writeback,
// a registered debug read port serves external tools, and a fixed tap exposes
// one register to the board.
//
// Debug handshake: the port has no ready signal, so a request is accepted on every
// edge where dbg_req=1. For each accepted request, dbg_valid is high for exactly the
// next cycle, with dbg_data carrying the pre-write value of reg[dbg_addr]. dbg_data
// holds its last value while dbg_valid is low.
module brq_regfile_mp #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter int                NUM_WR   = 1,
    parameter int                SP_IDX   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h00000200,
    parameter int                BYPASS   = 1,
    parameter int                TAP_IDX  = 15
) (
    input  logic                     brq_clk,
    input  logic                     brq_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    input  logic                     dbg_req,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic                     dbg_valid,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [DATA_W-1:0]        reg_tap
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];

    // Decode this cycle's writes per register. Later ports overwrite earlier ones,
    // so the highest-numbered port wins a collision. Index 0 is never hit.
    always_comb begin
        wr_hit = '0;
        for (int n = 0; n < DEPTH; n++) begin
            wr_val[n] = '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                wr_hit[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
                wr_val[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Register storage. Reset loads the stack pointer value; register 0 stays zero.
    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                regs[n] <= (n == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int n = 1; n < DEPTH; n++) begin
                if (wr_hit[n]) begin
                    regs[n] <= wr_val[n];
                end
            end
        end
    end

    // Pending-write scoreboard. A new reservation beats a same-cycle writeback.
    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q[0] <= 1'b0;
            for (int n = 1; n < DEPTH; n++) begin
                if (rsv_en && (rsv_addr == ADDR_W'(n))) begin
                    busy_q[n] <= 1'b1;
                end else if (wr_hit[n]) begin
                    busy_q[n] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy_q;
    assign reg_tap  = regs[TAP_IDX];

    // Read ports: stored value, or forwarded write data when bypass is enabled.
    // A forwarded register is no longer reported busy.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        assign ra  = rd_addr[g*ADDR_W +: ADDR_W];
        assign fwd = (BYPASS != 0) && wr_hit[ra];
        assign rd_data[g*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                             fwd        ? wr_val[ra] : regs[ra];
        assign rd_busy[g] = (ra != '0) && busy_q[ra] && !fwd;
    end

    // Debug read: sample the pre-write value and pulse valid for one cycle.
    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
        end else begin
            dbg_valid <= dbg_req;
            if (dbg_req) begin
                dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
            end
        end
    end

endmodule
